pipeline_mem: RTL and testbench
===============================

# pipeline_mem

Memory-access stage of the RISC-V pipeline, sitting directly downstream of the EX/MEM pipeline register and upstream of writeback. It consumes the registered EX outputs (ALU result, store data, rd, opcode, funct3) and performs LOAD/STORE accesses over a req/gnt/rvalid data-memory handshake. It applies byte-lane alignment and sign/zero extension, and stalls the pipeline while an access is outstanding. Non-memory instructions pass through with one-cycle latency.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  EX/MEM register holds a live instruction
- result_in  in  32  ALU result; effective address for LOAD/STORE
- data_in  in  32  store data (rs2)
- rd_in  in  5  destination register
- opcode_in  in  7  instruction opcode
- funct_3_in  in  3  access size/sign select
- stall_out  out  1  combinational; upstream must hold inputs while high
- mem_req  out  1  access request, held until mem_gnt
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address ({result[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  load data valid (one cycle)
- mem_rdata  in  32  load data word
- valid_out  out  1  one-cycle pulse: instruction retired to WB
- wb_result  out  32  writeback value
- wb_rd  out  5  writeback register
- wb_we  out  1  register-file write enable (never for rd = 0)
- fault_out  out  1  misaligned or illegal-funct3 access, qualified by valid_out

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, valid_in with non-memory opcode:
  - register wb_result = result_in, wb_rd = rd_in, valid_out = 1.
  - wb_we = (rd_in != 0) and opcode not in {STORE, BRANCH}.
- IDLE, valid_in with LOAD/STORE, aligned and legal:
  - latch address, data, rd, funct3, and the load/store flag.
  - go to REQ.
- REQ: mem_req = 1 until mem_gnt is sampled high.
  - STORE: on gnt, retire (valid_out = 1, wb_we = 0) and return to IDLE.
  - LOAD: on gnt, go to WAIT.
- WAIT: on mem_rvalid, register the extended data into wb_result, set wb_we = (rd != 0), pulse valid_out, return to IDLE.
- Alignment: halfword needs addr[0] = 0; word needs addr[1:0] = 0.
- Legal funct3: LOAD {0,1,2,4,5}; STORE {0,1,2}.
- Misaligned or illegal access:
  - no memory request is issued.
  - retire next cycle with valid_out = 1, fault_out = 1, wb_we = 0.
- Store lanes (off = addr[1:0]):
  - SB: wstrb = 4'b0001 << off, wdata = {4{d[7:0]}}.
  - SH: wstrb = 4'b0011 << off, wdata = {2{d[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = d.
- Load: shift rdata right by 8*off.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.

## Timing
- Non-memory and faulting instructions: latency 1; stall_out = 0.
- stall_out is asserted when any of these hold:
  - (IDLE and valid_in and legal memory op)
  - (REQ and not (store and mem_gnt))
  - (WAIT and not mem_rvalid)
- stall_out drops in the completion cycle, so upstream advances exactly once per instruction.
- Store latency: 1 + cycles to gnt. Load latency: 1 + cycles to gnt + cycles to rvalid, with minimum 3 (gnt and rvalid each sampled no earlier than the cycle after the previous step).
- mem_addr, mem_we, mem_wdata and mem_wstrb are stable for the whole time mem_req is high.
- mem_rvalid outside WAIT is ignored.
- Reset (async, any state):
  - FSM goes to IDLE.
  - mem_req, valid_out, wb_we and fault_out go to 0 immediately.
  - wb_result, wb_rd, mem_addr, mem_wdata and mem_wstrb go to 0.
  - An outstanding transaction is abandoned; a late rvalid after reset is ignored.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants: OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011.
  - funct3 constants: F3_B/H/W/BU/HU.
  - the mem_state_t enum (IDLE/REQ/WAIT).
- One combinational sub-module, lsu_align, containing store lane/strobe generation, load shift/extend, and the misalignment/illegal check.
- FSM and registers live in pipeline_mem.

## Test plan
- ADD, result 0x0000_1234, rd = 5 → next cycle valid_out = 1, wb_result = 0x1234, wb_we = 1, no mem_req, stall_out = 0.
- SB, addr 0x103, data 0xAABBCCDD, gnt after 2 cycles → mem_addr = 0x100, wstrb = 4'b1000, wdata = 0xDDDDDDDD; retire with wb_we = 0 in the gnt cycle.
- LB at 0x202, rdata 0x0080_0000 → wb_result = 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- LH at 0x201 → no mem_req, valid_out = 1 and fault_out = 1 next cycle, wb_we = 0.
- LW to rd = 0, rdata 0xDEADBEEF → valid_out pulses, wb_we = 0. Back-to-back second LW accepted only after stall_out falls, with exactly one retire each.
- Assert rst while in WAIT → mem_req/valid_out go to 0 at once, FSM is in IDLE, and a subsequent rvalid produces no valid_out.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and the memory-stage state encoding.
package riscv_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;
endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, shift/extend for loads, and access legality check.
module lsu_align
  import riscv_pkg::*;
(
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct_3_i,
  input  logic [XLEN-1:0] sdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      wstrb_o,
  output logic            fault_o,
  input  logic [1:0]      ld_off_i,
  input  logic [2:0]      ld_funct_3_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] ldata_o
);
  logic            misaligned;
  logic            illegal;
  logic [XLEN-1:0] ld_sh;

  always_comb begin
    misaligned = 1'b0;
    case (funct_3_i[1:0])
      2'b01:   misaligned = off_i[0];
      2'b10:   misaligned = |off_i;
      default: misaligned = 1'b0;
    endcase
    illegal = 1'b0;
    if (is_load_i)
      illegal = !(funct_3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else if (is_store_i)
      illegal = !(funct_3_i inside {F3_B, F3_H, F3_W});
    fault_o = (is_load_i | is_store_i) & (misaligned | illegal);
  end

  // Data is replicated across lanes so memory can pick it up from any offset.
  always_comb begin
    wdata_o = sdata_i;
    wstrb_o = 4'b1111;
    case (funct_3_i[1:0])
      2'b00: begin
        wdata_o = {4{sdata_i[7:0]}};
        wstrb_o = 4'b0001 << off_i;
      end
      2'b01: begin
        wdata_o = {2{sdata_i[15:0]}};
        wstrb_o = 4'b0011 << off_i;
      end
      default: ;
    endcase
  end

  assign ld_sh = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ldata_o = ld_sh;
    case (ld_funct_3_i)
      F3_B:    ldata_o = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_H:    ldata_o = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_BU:   ldata_o = {24'd0, ld_sh[7:0]};
      F3_HU:   ldata_o = {16'd0, ld_sh[15:0]};
      default: ldata_o = ld_sh;
    endcase
  end
endmodule

// File: rtl/pipeline_mem.sv
// MEM stage: issues loads/stores over req/gnt/rvalid, stalls upstream while busy,
// and retires every instruction to writeback as a one-cycle valid_out pulse.
module pipeline_mem
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] result_in,
  input  logic [XLEN-1:0] data_in,
  input  logic [4:0]      rd_in,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      funct_3_in,
  output logic            stall_out,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            valid_out,
  output logic [XLEN-1:0] wb_result,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            fault_out
);
  mem_state_t      state_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      wstrb_q;
  logic [4:0]      rd_q;
  logic [2:0]      f3_q;
  logic            store_q;
  logic            valid_q;
  logic            we_q;
  logic            fault_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      wbrd_q;

  logic            is_load;
  logic            is_store;
  logic            is_mem;
  logic            al_fault;
  logic [XLEN-1:0] al_wdata;
  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] ld_data;

  assign is_load  = (opcode_in == OP_LOAD);
  assign is_store = (opcode_in == OP_STORE);
  assign is_mem   = is_load | is_store;

  lsu_align u_align (
    .is_load_i    (is_load),
    .is_store_i   (is_store),
    .off_i        (result_in[1:0]),
    .funct_3_i    (funct_3_in),
    .sdata_i      (data_in),
    .wdata_o      (al_wdata),
    .wstrb_o      (al_wstrb),
    .fault_o      (al_fault),
    .ld_off_i     (addr_q[1:0]),
    .ld_funct_3_i (f3_q),
    .rdata_i      (mem_rdata),
    .ldata_o      (ld_data)
  );

  // Drops in the completion cycle so upstream advances exactly once per instruction.
  always_comb begin
    stall_out = 1'b0;
    case (state_q)
      IDLE:    stall_out = valid_in & is_mem & ~al_fault;
      REQ:     stall_out = ~(store_q & mem_gnt);
      WAIT:    stall_out = ~mem_rvalid;
      default: stall_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rd_q     <= '0;
      f3_q     <= '0;
      store_q  <= 1'b0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      result_q <= '0;
      wbrd_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            if (!is_mem) begin
              valid_q  <= 1'b1;
              result_q <= result_in;
              wbrd_q   <= rd_in;
              we_q     <= (rd_in != 5'd0) && (opcode_in != OP_BRANCH);
            end else if (al_fault) begin
              // Faulting access never reaches memory; it retires straight away.
              valid_q  <= 1'b1;
              fault_q  <= 1'b1;
              result_q <= result_in;
              wbrd_q   <= rd_in;
            end else begin
              addr_q  <= result_in;
              wdata_q <= is_store ? al_wdata : '0;
              wstrb_q <= is_store ? al_wstrb : 4'b0000;
              rd_q    <= rd_in;
              f3_q    <= funct_3_in;
              store_q <= is_store;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            if (store_q) begin
              valid_q <= 1'b1;
              wbrd_q  <= rd_q;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            valid_q  <= 1'b1;
            result_q <= ld_data;
            wbrd_q   <= rd_q;
            we_q     <= (rd_q != 5'd0);
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = store_q;
  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign valid_out = valid_q;
  assign wb_result = result_q;
  assign wb_rd     = wbrd_q;
  assign wb_we     = we_q;
  assign fault_out = fault_q;
endmodule

// File: tb/tb_pipeline_mem.sv
// Randomized bench for pipeline_mem: drives one instruction at a time, plays the
// memory side, and compares retirement against an arithmetic reference model.
module tb_pipeline_mem;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ADD    = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] result_in = '0;
  logic [31:0] data_in = '0;
  logic [4:0]  rd_in = '0;
  logic [6:0]  opcode_in = '0;
  logic [2:0]  funct_3_in = '0;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        valid_out;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        fault_out;

  int n_chk = 0;
  int n_fail = 0;

  pipeline_mem dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .result_in(result_in), .data_in(data_in),
    .rd_in(rd_in), .opcode_in(opcode_in), .funct_3_in(funct_3_in), .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .valid_out(valid_out), .wb_result(wb_result), .wb_rd(wb_rd), .wb_we(wb_we),
    .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_fault(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (op == OP_LOAD) begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    end else if (op == OP_STORE) begin
      if (f3 > 3'd2) return 1'b1;
    end else begin
      return 1'b0;
    end
    sz = 1 << f3[1:0];
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * a[1:0]);
    case (f3)
      3'd0:    return sh[7]  ? (sh & 32'hFF) - 32'h100 : (sh & 32'hFF);
      3'd1:    return sh[15] ? (sh & 32'hFFFF) - 32'h10000 : (sh & 32'hFFFF);
      3'd4:    return sh & 32'hFF;
      3'd5:    return sh & 32'hFFFF;
      default: return sh;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h01010101;
      3'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 32'h1 << a[1:0];
      3'd1:    return 32'h3 << a[1:0];
      default: return 32'hF;
    endcase
  endfunction

  // One instruction: gd = REQ cycles before gnt, rvd = WAIT cycles before rvalid.
  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                     input int gd, input int rvd, input logic [31:0] rdat);
    bit is_mem, is_st, flt, go, granted, done, req_seen, vo_early, bad_req, exp_we;
    int exp_st, cyc, st, reqn, wn;
    is_st  = (op == OP_STORE);
    is_mem = (op == OP_LOAD) || is_st;
    flt    = m_fault(op, f3, a);
    go     = is_mem && !flt;
    exp_st = !go ? 0 : (is_st ? 1 + gd : 2 + gd + rvd);
    exp_we = flt || is_st ? 1'b0 : (op == OP_LOAD ? (rd != 0) : (rd != 0 && op != OP_BRANCH));
    cyc = 0; st = 0; reqn = 0; wn = 0;
    granted = 0; done = 0; req_seen = 0; vo_early = 0; bad_req = 0;
    valid_in = 1'b1; opcode_in = op; funct_3_in = f3; result_in = a; data_in = d; rd_in = rd;
    while (!done && cyc < 64) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (valid_out) vo_early = 1;
      if (mem_req) begin
        req_seen = 1;
        if (!go || mem_addr !== (a & 32'hFFFF_FFFC) || mem_we !== is_st) bad_req = 1;
        if (is_st && (mem_wdata !== m_wdata(f3, d) || 32'(mem_wstrb) !== m_wstrb(f3, a))) bad_req = 1;
        if (reqn == gd) begin mem_gnt = 1'b1; granted = 1; end
        reqn++;
        mem_rvalid = 1'($urandom_range(0, 1));
      end else if (granted) begin
        if (wn == rvd) begin mem_rvalid = 1'b1; mem_rdata = rdat; end
        wn++;
      end else begin
        mem_rvalid = 1'($urandom_range(0, 1));
      end
      #1;
      if (stall_out) st++; else done = 1;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    valid_in = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!done) chk({nm, ".timeout"}, 32'd1, 32'd0);
    chk({nm, ".valid"}, 32'(valid_out), 32'd1);
    chk({nm, ".fault"}, 32'(fault_out), 32'(flt));
    chk({nm, ".we"}, 32'(wb_we), 32'(exp_we));
    if (!flt && !is_st) begin
      chk({nm, ".rd"}, 32'(wb_rd), 32'(rd));
      chk({nm, ".result"}, wb_result, op == OP_LOAD ? m_load(f3, a, rdat) : a);
    end
    chk({nm, ".stalls"}, st, exp_st);
    chk({nm, ".req_seen"}, 32'(req_seen), 32'(go));
    chk({nm, ".req_fields"}, 32'(bad_req), 32'd0);
    chk({nm, ".early_valid"}, 32'(vo_early), 32'd0);
    // Idle cycle with a stray rvalid: must be ignored and valid_out must be a pulse.
    mem_rvalid = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk({nm, ".pulse"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    logic [6:0] op;
    logic [6:0] nm_ops [4];
    nm_ops[0] = OP_ADD; nm_ops[1] = OP_ADDI; nm_ops[2] = OP_BRANCH; nm_ops[3] = OP_LUI;

    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(valid_out), 32'd0);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.we", 32'(wb_we), 32'd0);
    chk("rst.fault", 32'(fault_out), 32'd0);
    chk("rst.result", wb_result, 32'd0);
    chk("rst.rd", 32'(wb_rd), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst.stall", 32'(stall_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("add",    OP_ADD,   3'd0, 32'h0000_1234, 32'h0,          5'd5, 0, 0, 32'h0);
    run("sb",     OP_STORE, 3'd0, 32'h0000_0103, 32'hAABB_CCDD,  5'd0, 2, 0, 32'h0);
    run("lb",     OP_LOAD,  3'd0, 32'h0000_0202, 32'h0,          5'd7, 0, 0, 32'h0080_0000);
    run("lbu",    OP_LOAD,  3'd4, 32'h0000_0202, 32'h0,          5'd7, 1, 1, 32'h0080_0000);
    run("lh_mis", OP_LOAD,  3'd1, 32'h0000_0201, 32'h0,          5'd9, 0, 0, 32'h0);
    run("lw_r0",  OP_LOAD,  3'd2, 32'h0000_0400, 32'h0,          5'd0, 0, 0, 32'hDEAD_BEEF);
    run("lw_2",   OP_LOAD,  3'd2, 32'h0000_0404, 32'h0,          5'd8, 0, 0, 32'h1357_9BDF);
    run("sh",     OP_STORE, 3'd1, 32'h0000_0206, 32'h1234_5678,  5'd1, 0, 0, 32'h0);
    run("sw_ill", OP_STORE, 3'd3, 32'h0000_0208, 32'h1,          5'd2, 0, 0, 32'h0);
    run("lh",     OP_LOAD,  3'd1, 32'h0000_0502, 32'h0,          5'd4, 0, 2, 32'h8001_0000);
    run("beq",    OP_BRANCH,3'd0, 32'h0000_0042, 32'h0,          5'd3, 0, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       op = nm_ops[$urandom_range(0, 3)];
        1:       op = OP_LOAD;
        default: op = OP_STORE;
      endcase
      run($sformatf("rnd%0d", i), op, 3'($urandom_range(0, 7)), $urandom, $urandom,
          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Reset while a load sits in WAIT.
    valid_in = 1'b1; opcode_in = OP_LOAD; funct_3_in = 3'd2; result_in = 32'h300; rd_in = 5'd3;
    @(posedge clk); @(negedge clk);
    mem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_gnt = 1'b0; valid_in = 1'b0;
    #1;
    chk("wrst.in_wait", 32'(stall_out), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("wrst.req", 32'(mem_req), 32'd0);
    chk("wrst.valid", 32'(valid_out), 32'd0);
    chk("wrst.we", 32'(wb_we), 32'd0);
    chk("wrst.idle", 32'(stall_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0;
    chk("wrst.late_rvalid", 32'(valid_out), 32'd0);
    run("post_rst", OP_ADDI, 3'd0, 32'h0000_0077, 32'h0, 5'd6, 0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
